// File: rtl/ring_meas_sched.sv
// ring_meas_sched: measurement scheduler for the ring-oscillator frequency channels.
// Shares one capture path between pCHANS ring counters. For each selected channel it
// runs a counter clear, a gate window of exactly pWINDOW clocks, a settle interval for
// the grey synchronizer, then samples the grey count and presents it in binary.
//
// Ports:
//   i_clk, i_rst_n      reference clock, asynchronous active-low reset
//   i_start             start a sweep (IDLE only)
//   i_continuous        sampled in NEXT: wrap and sweep again
//   i_abort             synchronous abort to IDLE, highest priority
//   i_chan_mask         channels to measure, latched at start and at each wrap
//   i_count_grey        synchronized grey count of channel o_sel
//   o_sel               capture mux select
//   o_clr               counter clear to the selected ring counter
//   o_gate              one-hot count enable
//   o_busy              high in every state except IDLE
//   o_valid             one-cycle pulse, new o_result/o_result_chan/o_ovf
//   o_result            binary count of the last sampled channel
//   o_result_chan       channel of o_result
//   o_ovf               o_result is all ones
//   o_done              one-cycle pulse at the end of a non-continuous sweep
module ring_meas_sched #(
    parameter int unsigned pCHANS  = 4,
    parameter int unsigned pCW     = 16,
    parameter int unsigned pWINDOW = 1000,
    parameter int unsigned pCLR    = 4,
    parameter int unsigned pSETTLE = 4,
    localparam int unsigned SW     = (pCHANS > 1) ? $clog2(pCHANS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_abort,
    input  logic [pCHANS-1:0] i_chan_mask,
    input  logic [pCW-1:0]    i_count_grey,
    output logic [SW-1:0]     o_sel,
    output logic              o_clr,
    output logic [pCHANS-1:0] o_gate,
    output logic              o_busy,
    output logic              o_valid,
    output logic [pCW-1:0]    o_result,
    output logic [SW-1:0]     o_result_chan,
    output logic              o_ovf,
    output logic              o_done
);

    localparam int unsigned TMAX0 = (pWINDOW > pCLR) ? pWINDOW : pCLR;
    localparam int unsigned TMAX  = (TMAX0 > pSETTLE) ? TMAX0 : pSETTLE;
    localparam int unsigned TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_SAMPLE, S_NEXT
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_timer;
    logic [pCHANS-1:0]   r_mask;
    logic [SW-1:0]       r_sel;
    logic                r_clr;
    logic [pCHANS-1:0]   r_gate;
    logic                r_busy;
    logic                r_valid;
    logic [pCW-1:0]      r_result;
    logic [SW-1:0]       r_result_chan;
    logic                r_ovf;
    logic                r_done;

    logic [pCW-1:0]      w_bin;
    logic [pCHANS-1:0]   w_above;
    logic [SW-1:0]       w_first_new;
    logic [SW-1:0]       w_first_above;
    logic                w_has_above;
    logic [pCHANS-1:0]   w_sel_onehot;

    // Lowest set bit of a channel mask (0 when empty).
    function automatic logic [SW-1:0] f_lowest(input logic [pCHANS-1:0] m);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = int'(pCHANS) - 1; i >= 0; i--) begin
            if (m[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    // Grey-to-binary: each binary bit is the running XOR from the MSB down.
    always_comb begin
        w_bin = '0;
        w_bin[pCW-1] = i_count_grey[pCW-1];
        for (int i = int'(pCW) - 2; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ i_count_grey[i];
        end
    end

    // Latched channels strictly above the current selection.
    always_comb begin
        w_above = '0;
        for (int i = 0; i < int'(pCHANS); i++) begin
            w_above[i] = r_mask[i] && (i > int'(r_sel));
        end
    end

    assign w_has_above   = |w_above;
    assign w_first_above = f_lowest(w_above);
    assign w_first_new   = f_lowest(i_chan_mask);
    assign w_sel_onehot  = pCHANS'(1) << r_sel;

    // Scheduler FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_mask        <= '0;
            r_sel         <= '0;
            r_clr         <= 1'b0;
            r_gate        <= '0;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
            r_result      <= '0;
            r_result_chan <= '0;
            r_ovf         <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (i_abort) begin
                r_state <= S_IDLE;
                r_timer <= '0;
                r_clr   <= 1'b0;
                r_gate  <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && (|i_chan_mask)) begin
                            r_mask  <= i_chan_mask;
                            r_sel   <= w_first_new;
                            r_clr   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_timer <= TW'(pCLR - 1);
                            r_state <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        if (r_timer == '0) begin
                            r_clr   <= 1'b0;
                            r_gate  <= w_sel_onehot;
                            r_timer <= TW'(pWINDOW - 1);
                            r_state <= S_GATE;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    S_GATE: begin
                        if (r_timer == '0) begin
                            r_gate  <= '0;
                            r_timer <= TW'(pSETTLE - 1);
                            r_state <= S_SETTLE;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (r_timer == '0) begin
                            r_state <= S_SAMPLE;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    S_SAMPLE: begin
                        r_result      <= w_bin;
                        r_result_chan <= r_sel;
                        r_ovf         <= &w_bin;
                        r_valid       <= 1'b1;
                        r_state       <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (w_has_above) begin
                            r_sel   <= w_first_above;
                            r_clr   <= 1'b1;
                            r_timer <= TW'(pCLR - 1);
                            r_state <= S_CLEAR;
                        end else if (i_continuous && (|i_chan_mask)) begin
                            r_mask  <= i_chan_mask;
                            r_sel   <= w_first_new;
                            r_clr   <= 1'b1;
                            r_timer <= TW'(pCLR - 1);
                            r_state <= S_CLEAR;
                        end else begin
                            // An empty wrap mask ends the sweep like a one-shot sweep.
                            if (i_continuous) r_mask <= i_chan_mask;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_clr   <= 1'b0;
                        r_gate  <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_sel         = r_sel;
    assign o_clr         = r_clr;
    assign o_gate        = r_gate;
    assign o_busy        = r_busy;
    assign o_valid       = r_valid;
    assign o_result      = r_result;
    assign o_result_chan = r_result_chan;
    assign o_ovf         = r_ovf;
    assign o_done        = r_done;

endmodule

// File: tb/tb_ring_meas_sched.sv
// tb_ring_meas_sched: scoreboard bench for ring_meas_sched. The driver issues sweeps and
// pushes the expected results/done pulses; a negedge monitor pops and compares them and
// also checks the clear/gate/busy timeline and result holding every cycle.
module tb_ring_meas_sched;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int WIN = 10;
    localparam int CLR = 4;
    localparam int SET = 4;
    localparam int P   = CLR + WIN + SET + 2;

    typedef struct {
        int          chan;
        logic [15:0] res;
        bit          ovf;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            cont = 1'b0;
    logic            abort_i = 1'b0;
    logic [NCH-1:0]  mask = '0;
    logic [CW-1:0]   count_grey;
    logic [1:0]      sel;
    logic            clr_o;
    logic [NCH-1:0]  gate;
    logic            busy;
    logic            valid;
    logic [CW-1:0]   result;
    logic [1:0]      result_chan;
    logic            ovf;
    logic            done;

    logic [CW-1:0]   grey_tab [NCH];
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;

    exp_t            vq[$];
    int              dq[$];
    int              tl_list[$];
    int              tl_start = 0;
    int              tl_end = 0;
    logic [15:0]     last_res = '0;
    int              last_chan = 0;
    bit              last_ovf = 1'b0;

    ring_meas_sched #(
        .pCHANS(NCH), .pCW(CW), .pWINDOW(WIN), .pCLR(CLR), .pSETTLE(SET)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_continuous(cont),
        .i_abort(abort_i), .i_chan_mask(mask), .i_count_grey(count_grey),
        .o_sel(sel), .o_clr(clr_o), .o_gate(gate), .o_busy(busy), .o_valid(valid),
        .o_result(result), .o_result_chan(result_chan), .o_ovf(ovf), .o_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ring counter model: the capture mux presents the selected channel's grey count.
    assign count_grey = grey_tab[sel];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference conversion: binary = XOR of all right shifts of the grey code.
    function automatic logic [15:0] g2b(input logic [15:0] g);
        logic [15:0] b = '0;
        for (int s = 0; s < 16; s++) b ^= (g >> s);
        return b;
    endfunction

    // Arm the model for a sweep whose start edge is the next posedge, then pulse start.
    task automatic issue(input logic [NCH-1:0] m, input int lst[$]);
        exp_t e;
        @(negedge clk);
        tl_list  = lst;
        tl_start = cyc + 1;
        tl_end   = tl_start + lst.size() * P;
        for (int j = 0; j < lst.size(); j++) begin
            e.chan = lst[j];
            e.res  = g2b(grey_tab[lst[j]]);
            e.ovf  = (e.res == 16'hFFFF);
            e.cyc  = tl_start + j * P + P - 1;
            vq.push_back(e);
        end
        dq.push_back(tl_end);
        mask  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic void bits_of(input logic [NCH-1:0] m, output int q[$]);
        q = {};
        for (int i = 0; i < NCH; i++) if (m[i]) q.push_back(i);
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic rand_grey();
        for (int i = 0; i < NCH; i++)
            grey_tab[i] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
    endtask

    // Monitor: scoreboard pops plus per-cycle timeline and hold checks.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            int   off, j, r;
            if (valid) begin
                if (vq.size() == 0) begin
                    chk("valid_unexpected", 32'(valid), 32'd0);
                end else begin
                    e = vq.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                    chk("valid_chan", 32'(result_chan), 32'(e.chan));
                    chk("valid_result", 32'(result), 32'(e.res));
                    chk("valid_ovf", 32'(ovf), 32'(e.ovf));
                    last_res = e.res; last_chan = e.chan; last_ovf = e.ovf;
                end
            end else if (vq.size() != 0 && vq[0].cyc < cyc) begin
                chk("valid_missing", 32'(valid), 32'd1);
                void'(vq.pop_front());
            end
            if (done) begin
                if (dq.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
                else chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
            end else if (dq.size() != 0 && dq[0] < cyc) begin
                chk("done_missing", 32'(done), 32'd1);
                void'(dq.pop_front());
            end
            if (cyc >= tl_start && cyc < tl_end) begin
                off = cyc - tl_start;
                j   = off / P;
                r   = off % P;
                if (j < tl_list.size()) begin
                    chk("busy", 32'(busy), 32'd1);
                    chk("sel", 32'(sel), 32'(tl_list[j]));
                    chk("clr", 32'(clr_o), (r < CLR) ? 32'd1 : 32'd0);
                    chk("gate", 32'(gate),
                        (r >= CLR && r < CLR + WIN) ? (32'd1 << tl_list[j]) : 32'd0);
                end
            end else begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_clr", 32'(clr_o), 32'd0);
                chk("idle_gate", 32'(gate), 32'd0);
            end
            chk("hold_result", 32'(result), 32'(last_res));
            chk("hold_chan", 32'(result_chan), 32'(last_chan));
            chk("hold_ovf", 32'(ovf), 32'(last_ovf));
        end
    end

    initial begin
        int lst[$];
        int k;
        for (int i = 0; i < NCH; i++) grey_tab[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_clr", 32'(clr_o), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full sweep of all four channels.
        rand_grey();
        bits_of(4'b1111, lst);
        issue(4'b1111, lst);
        wait_until(tl_end + 3);

        // Overflow and small-value conversion.
        grey_tab[0] = 16'h8000; grey_tab[1] = 16'h0003;
        bits_of(4'b0011, lst);
        issue(4'b0011, lst);
        wait_until(tl_end + 3);

        // Continuous sweep with a mid-sweep mask change taking effect at the wrap.
        rand_grey();
        cont = 1'b1;
        lst = '{1, 3, 0};
        issue(4'b1010, lst);
        k = tl_start;
        wait_until(k + 10);
        mask = 4'b0001;
        wait_until(k + 2 * P + 5);
        cont = 1'b0;
        wait_until(tl_end + 3);

        // Abort during the gate of channel 2, then abort together with start in IDLE.
        rand_grey();
        bits_of(4'b1111, lst);
        issue(4'b1111, lst);
        k = tl_start;
        wait_until(k + 2 * P + 7);
        abort_i = 1'b1;
        vq.delete(); dq.delete();
        tl_end = cyc + 1;
        @(negedge clk);
        abort_i = 1'b0;
        repeat (2) @(negedge clk);
        abort_i = 1'b1; start = 1'b1; mask = 4'b1111;
        @(negedge clk);
        abort_i = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);

        // Start with an empty mask is ignored.
        mask = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized one-shot sweeps with ignored start pulses and mask churn.
        for (int n = 0; n < 8; n++) begin
            logic [NCH-1:0] m;
            rand_grey();
            m = NCH'($urandom_range(1, 15));
            bits_of(m, lst);
            issue(m, lst);
            while (cyc < tl_end + 2) begin
                if (cyc < tl_end - 2 && $urandom_range(0, 7) == 0) start = 1'b1;
                else start = 1'b0;
                if ($urandom_range(0, 5) == 0) mask = NCH'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // Asynchronous reset in the middle of channel 1's gate.
        grey_tab[0] = 16'h1234;
        bits_of(4'b0011, lst);
        issue(4'b0011, lst);
        k = tl_start;
        wait_until(k + P + 8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gate", 32'(gate), 32'd0);
        chk("arst_clr", 32'(clr_o), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        vq.delete(); dq.delete();
        tl_start = 0; tl_end = 0;
        last_res = '0; last_chan = 0; last_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Recovery sweep after reset.
        rand_grey();
        bits_of(4'b0100, lst);
        issue(4'b0100, lst);
        wait_until(tl_end + 3);

        chk("pending_valid", 32'(vq.size()), 32'd0);
        chk("pending_done", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_meas_sched.md
Name: ring_meas_sched

Overview:
Measurement scheduler for the ring-oscillator frequency channels (5/11/23/47-stage rings and their grey counters). Shares one capture path between up to pCHANS ring counters. Each selected channel in turn gets a counter clear, a gate window of exactly pWINDOW reference clocks, a settle interval for the grey-code synchronizer, and a sample. The sampled grey count is converted to binary and presented with its channel index to the scan/LED readout.

Parameters:
pCHANS, 4, number of ring-counter channels (2..8)
pCW, 16, grey count width
pWINDOW, 1000, gate length in i_clk cycles (>=1)
pCLR, 4, counter-clear length in i_clk cycles (>=1)
pSETTLE, 4, post-gate settle cycles before sampling (>=2)

Ports:
i_clk  in  1  reference clock (external io_in[0] clock)
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start a sweep; sampled only in IDLE
i_continuous  in  1  sampled in NEXT: 1 = wrap and sweep again
i_abort  in  1  synchronous abort to IDLE from any state
i_chan_mask  in  pCHANS  channels to measure; latched at start and at each wrap
i_count_grey  in  pCW  grey count of channel o_sel, already synchronized to i_clk
o_sel  out  clog2(pCHANS)  channel index driving the capture mux
o_clr  out  1  counter clear to the selected ring counter
o_gate  out  pCHANS  one-hot count enable; at most one bit set
o_busy  out  1  high in every state except IDLE
o_valid  out  1  one-cycle pulse: o_result/o_result_chan are new
o_result  out  pCW  binary count of the last sampled channel
o_result_chan  out  clog2(pCHANS)  channel of o_result
o_ovf  out  1  valid with o_result: binary count == all ones
o_done  out  1  one-cycle pulse at the end of a non-continuous sweep

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all outputs 0; latched mask 0; timer 0.
- The FSM has the states IDLE, CLEAR, GATE, SETTLE, SAMPLE and NEXT. It uses one down-counter timer, clog2(max(pWINDOW,pCLR,pSETTLE)+1) bits wide.
- IDLE to CLEAR: requires i_start=1 and i_chan_mask!=0.
  - Latch the mask.
  - o_sel takes the lowest set bit.
  - If i_start=1 with mask==0, stay in IDLE with no o_done pulse.
- CLEAR: o_clr=1 for exactly pCLR cycles, then go to GATE.
- GATE: o_gate[o_sel]=1 for exactly pWINDOW cycles, then go to SETTLE. o_clr=0 throughout.
- SETTLE: o_gate=0 for pSETTLE cycles, then go to SAMPLE.
- SAMPLE (one cycle): register gray-to-binary of i_count_grey into o_result.
  - Set o_result_chan=o_sel and o_ovf=(binary==2^pCW-1).
  - o_valid=1 in the following cycle only.
  - Go to NEXT.
- NEXT (one cycle): choose the next channel.
  - If a set bit exists in the latched mask above o_sel, o_sel takes the lowest such bit; go to CLEAR.
  - Otherwise, if i_continuous=1, relatch i_chan_mask and o_sel takes its lowest set bit; go to CLEAR.
    - If the new mask is 0, go to IDLE and pulse o_done.
  - Otherwise go to IDLE and pulse o_done for one cycle.
- Cycle timing, with i_start sampled at edge k:
  - o_clr high for cycles k+1..k+pCLR.
  - gate high for cycles k+pCLR+1..k+pCLR+pWINDOW.
  - SAMPLE at k+pCLR+pWINDOW+pSETTLE+1.
  - o_valid at +1 after SAMPLE.
  - Per-channel period = pCLR+pWINDOW+pSETTLE+2.
- o_sel changes only in IDLE->CLEAR and NEXT; it is stable from CLEAR through SAMPLE.
- i_start while busy: ignored.
- i_chan_mask changes mid-sweep: no effect until the wrap.
- i_abort: takes priority over every transition.
  - Next edge: IDLE, o_gate=0, o_clr=0, no o_valid, no o_done.
  - o_result, o_result_chan and o_ovf are held.
  - i_abort and i_start together in IDLE: abort wins, stay IDLE.
- Reset mid-sweep: outputs are cleared immediately (async); o_gate is never left asserted.
- o_result, o_result_chan and o_ovf hold their values until the next SAMPLE.

Test Plan:
1. Set pCHANS=4, pCLR=4, pWINDOW=10, pSETTLE=4, mask=4'b1111, continuous=0, and pulse start. Required: o_sel sequence 0,1,2,3 with 20 cycles per channel. o_valid fires 4 times with o_result_chan 0..3. o_done pulses once, 80 cycles after start, then busy=0.
2. Drive i_count_grey=16'h8000 (binary 0xFFFF) during SAMPLE. Required: o_result=0xFFFF, o_ovf=1. With grey 16'h0003, required o_result=0x0002, o_ovf=0.
3. Use mask=4'b1010 with continuous=1, and change the mask to 4'b0001 mid-sweep. Required: channels 1, then 3, then wrap to 0 only. No o_done while continuous stays 1.
4. Assert i_abort during GATE of channel 2. Required: next cycle o_gate=0, state IDLE, busy=0, no o_valid. Previous o_result held.
5. Pulse start with mask=0. Required: stays IDLE, busy=0, no o_done. Pulse start again during a sweep: required no change to the sequence.
6. Pull i_rst_n low mid-GATE, asynchronously between edges. Required: o_gate, o_clr and o_busy are 0 before the next edge, and o_result=0.
